ccg_tt_sweeper: RTL and testbench
=================================

Name: ccg_tt_sweeper

Overview:
- Sequential harness stage placed directly upstream and downstream of a generated N_IN-input / N_OUT-output combinational circuit-under-test (CUT).
- On start, drives every input pattern 0..2^N_IN-1 onto the CUT and waits SETTLE cycles per pattern.
- Samples the CUT outputs into a truth-table buffer.
- Streams the captured table out over a valid/ready interface, one entry per pattern, for dataset labelling and equivalence checking.

Parameters:
- N_IN, 4, CUT input count; table depth = 2^N_IN.
- N_OUT, 5, CUT output count; table entry width.
- SETTLE, 1, cycles (>=0) to hold each pattern before sampling.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last stream beat is accepted.
- x_o  output  N_IN  registered pattern driven to CUT inputs.
- f_i  input  N_OUT  CUT outputs (combinational function of x_o).
- tt_valid  output  1  stream entry valid.
- tt_ready  input  1  downstream accept.
- tt_index  output  N_IN  pattern index of current entry.
- tt_data  output  N_OUT  captured CUT outputs for tt_index.
- tt_last  output  1  high with the entry at index 2^N_IN-1.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset: state=IDLE; busy, done, tt_valid, tt_last = 0; x_o, tt_index, tt_data = 0. Buffer contents are don't-care.
- FSM states: IDLE, APPLY, STREAM, DONE.
- IDLE:
  - start=1 sets idx=0, x_o=0, settle_cnt=SETTLE, then goes to APPLY.
  - start=0 holds.
- APPLY:
  - x_o=idx, held stable.
  - If settle_cnt!=0: decrement.
  - If settle_cnt==0: mem[idx]<=f_i.
    - If idx==2^N_IN-1: go to STREAM with rd_idx=0.
    - Otherwise: idx++, x_o<=idx+1, settle_cnt<=SETTLE.
  - Each pattern occupies exactly SETTLE+1 cycles. A full sweep takes 2^N_IN*(SETTLE+1) cycles.
- STREAM:
  - tt_valid=1, tt_index=rd_idx, tt_data=mem[rd_idx], tt_last=(rd_idx==2^N_IN-1). All are registered outputs.
  - On tt_valid&&tt_ready: if tt_last, go to DONE; otherwise rd_idx++ and next entry presented the following cycle.
  - With tt_ready held high, throughput is one entry per cycle.
  - While tt_ready=0, tt_index, tt_data and tt_last hold stable. tt_valid never deasserts before acceptance.
- DONE: done=1 for exactly one cycle, tt_valid=0, then go to IDLE.
- x_o holds its last value (2^N_IN-1) after APPLY until the next start.
- start while busy=1: ignored, no restart.
- start asserted in the same cycle as done: ignored; start is accepted only in IDLE.
- rst mid-sweep or mid-stream: immediate return to reset values. No done pulse. Partial table is discarded.
- Index counters are N_IN+1 bits internally so the terminal compare never wraps.

Optional Feature:
- Macro CCG_TT_SIGNATURE_EN adds a 16-bit MISR signature over captured outputs, plus port sig_o (output, 16 bits).
- MISR is cleared to 16'h0000 on start accepted in IDLE.
- On each APPLY capture: sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {{(16-N_OUT){1'b0}}, f_i}.
- Requires N_OUT<=16.
- sig_o is stable from the first STREAM cycle until the next start; reset value is 0.
- Without the macro: no sig_o port and no MISR logic. All other behaviour is identical.

Decomposition:
- Package ccg_tt_pkg holds:
  - FSM state enum tt_state_e: IDLE, APPLY, STREAM, DONE.
  - MISR polynomial constant CCG_TT_MISR_TAPS = 16'hB400.
  - Function tt_depth(n_in) = 1<<n_in.
- One sub-module, ccg_tt_buf: 2^N_IN x N_OUT register file with one write port and one registered read port, used for the capture buffer.

Test Plan:
- Loopback CUT f_i={x_o[0],x_o}, N_IN=4, N_OUT=5, SETTLE=1, tt_ready=1; pulse start:
  - 32 APPLY cycles.
  - 16 beats where index i has data {i[0],i] (i=5 gives 5'h15, i=15 gives 5'h1F).
  - tt_last only on i=15.
  - done one cycle after that beat.
- Same setup, tt_ready toggled 1,0,0,1 repeating: every entry appears exactly once, in order, held stable while stalled; no drop and no duplicate.
- SETTLE=0 versus SETTLE=3: x_o changes every 1 cycle and every 4 cycles respectively; sweep lengths are 16 and 64 cycles; captured tables are identical.
- Pulse start during APPLY and during STREAM: no restart and no index change; exactly one done per accepted start.
- Assert rst at beat index 7 of STREAM:
  - Next cycle busy=0, tt_valid=0, x_o=0, with no done pulse.
  - A subsequent start yields a full, correct 16-entry table.
- With CCG_TT_SIGNATURE_EN, the loopback CUT must give sig_o equal to a bench reference MISR computed over the 16 captures. A second identical sweep must give the same sig_o, proving the MISR is cleared on start.

Source files
------------

// File: rtl/ccg_tt_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM states, MISR taps,
// table depth and the MISR step used when CCG_TT_SIGNATURE_EN is defined.
package ccg_tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

    localparam logic [15:0] CCG_TT_MISR_TAPS = 16'hB400;

    function automatic int tt_depth(input int n_in);
        return 32'sd1 << n_in;
    endfunction

    // Shift in the tap parity, then fold the new capture into the low bits.
    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] din);
        return {sig[14:0], ^(sig & CCG_TT_MISR_TAPS)} ^ din;
    endfunction

endpackage

// File: rtl/ccg_tt_buf.sv
// Capture buffer: 2^N_IN x N_OUT register file, one write port and one
// registered read port whose output register clears on reset.
module ccg_tt_buf
    import ccg_tt_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [N_IN-1:0]  waddr_i,
    input  logic [N_OUT-1:0] wdata_i,
    input  logic             re_i,
    input  logic [N_IN-1:0]  raddr_i,
    output logic [N_OUT-1:0] rdata_o
);

    localparam int DEPTH = tt_depth(N_IN);

    logic [N_OUT-1:0] mem_q [DEPTH];
    logic [N_OUT-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ccg_tt_sweeper.sv
// Exhaustive input sweeper for a combinational CUT that captures its truth table
// and streams it out; CCG_TT_SIGNATURE_EN adds a MISR signature on sig_o.
module ccg_tt_sweeper
    import ccg_tt_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 5,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [N_IN-1:0]  x_o,
    input  logic [N_OUT-1:0] f_i,
    output logic             tt_valid,
    input  logic             tt_ready,
    output logic [N_IN-1:0]  tt_index,
    output logic [N_OUT-1:0] tt_data,
`ifdef CCG_TT_SIGNATURE_EN
    output logic [15:0]      sig_o,
`endif
    output logic             tt_last
);

    localparam int DEPTH = tt_depth(N_IN);
    localparam int CW    = N_IN + 1;
    localparam int SW    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
    localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);

    tt_state_e        state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    rd_q, rd_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [N_IN-1:0]  x_q, x_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             we_s;
    logic             re_s;
    logic [N_IN-1:0]  raddr_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            rd_q     <= '0;
            settle_q <= '0;
            x_q      <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rd_q     <= rd_d;
            settle_q <= settle_d;
            x_q      <= x_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rd_d     = rd_q;
        settle_d = settle_q;
        x_d      = x_q;
        valid_d  = valid_q;
        last_d   = last_q;
        we_s     = 1'b0;
        re_s     = 1'b0;
        raddr_s  = rd_q[N_IN-1:0];
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d    = '0;
                    rd_d     = '0;
                    x_d      = '0;
                    settle_d = SETTLE_V;
                    state_d  = APPLY;
                end else begin
                    state_d = IDLE;
                end
            end
            APPLY: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SW'(1);
                end else begin
                    we_s = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // Prefetch entry 0 so the first STREAM cycle already presents it.
                        state_d = STREAM;
                        rd_d    = '0;
                        re_s    = 1'b1;
                        raddr_s = '0;
                        valid_d = 1'b1;
                        last_d  = (LAST_IDX == CW'(0));
                    end else begin
                        idx_d    = idx_q + CW'(1);
                        x_d      = idx_d[N_IN-1:0];
                        settle_d = SETTLE_V;
                    end
                end
            end
            STREAM: begin
                if (tt_ready) begin
                    if (last_q) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        rd_d    = rd_q + CW'(1);
                        re_s    = 1'b1;
                        raddr_s = rd_d[N_IN-1:0];
                        last_d  = (rd_d == LAST_IDX);
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    ccg_tt_buf #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_s),
        .waddr_i (idx_q[N_IN-1:0]),
        .wdata_i (f_i),
        .re_i    (re_s),
        .raddr_i (raddr_s),
        .rdata_o (tt_data)
    );

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign x_o      = x_q;
    assign tt_valid = valid_q;
    assign tt_index = rd_q[N_IN-1:0];
    assign tt_last  = last_q;

`ifdef CCG_TT_SIGNATURE_EN
    logic        start_acc_s;
    logic [15:0] sig_q;

    assign start_acc_s = (state_q == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 16'h0000;
        end else if (start_acc_s) begin
            sig_q <= 16'h0000;
        end else if (we_s) begin
            sig_q <= misr_step(sig_q, 16'(f_i));
        end
    end

    assign sig_o = sig_q;
`endif

endmodule

// File: tb/tb_ccg_tt_sweeper.sv
// Self-checking bench for ccg_tt_sweeper: three instances (SETTLE 1, 0, 3) driven
// by a loopback or random-table CUT and compared against a truth-table model.
module tb_ccg_tt_sweeper;

    localparam int N_IN  = 4;
    localparam int N_OUT = 5;
    localparam int DEPTH = 16;
    localparam int NDUT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_r   [NDUT];
    logic             start_r [NDUT];
    logic             ready_r [NDUT];
    logic             busy_w  [NDUT];
    logic             done_w  [NDUT];
    logic             valid_w [NDUT];
    logic             last_w  [NDUT];
    logic [N_IN-1:0]  x_w     [NDUT];
    logic [N_IN-1:0]  index_w [NDUT];
    logic [N_OUT-1:0] f_w     [NDUT];
    logic [N_OUT-1:0] data_w  [NDUT];
`ifdef CCG_TT_SIGNATURE_EN
    logic [15:0]      sig_w   [NDUT];
`endif

    logic [N_OUT-1:0] lut [DEPTH];
    logic [N_OUT-1:0] cap [NDUT][DEPTH];
    bit               use_lut = 1'b0;

    int checks = 0;
    int errors = 0;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            assign f_w[g] = use_lut ? lut[x_w[g]] : {x_w[g][0], x_w[g]};
            ccg_tt_sweeper #(
                .N_IN   (N_IN),
                .N_OUT  (N_OUT),
                .SETTLE ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
            ) u_dut (
                .clk      (clk),
                .rst      (rst_r[g]),
                .start    (start_r[g]),
                .busy     (busy_w[g]),
                .done     (done_w[g]),
                .x_o      (x_w[g]),
                .f_i      (f_w[g]),
                .tt_valid (valid_w[g]),
                .tt_ready (ready_r[g]),
                .tt_index (index_w[g]),
                .tt_data  (data_w[g]),
`ifdef CCG_TT_SIGNATURE_EN
                .sig_o    (sig_w[g]),
`endif
                .tt_last  (last_w[g])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference CUT: what the truth table entry for pattern i must be.
    function automatic logic [N_OUT-1:0] model_f(input int i);
        logic [N_IN-1:0] v;
        v = i[N_IN-1:0];
        return use_lut ? lut[v] : {v[0], v};
    endfunction

    function automatic logic [15:0] model_sig();
        logic [15:0] s;
        s = 16'h0000;
        for (int i = 0; i < DEPTH; i++) begin
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {11'b0, model_f(i)};
        end
        return s;
    endfunction

    task automatic run_sweep(input int g, input int rmode, input bit poke_apply,
                             input bit poke_stream, input bit start_at_done,
                             input int exp_apply, input string tag);
        int apply_cyc, beats, dones, stream_cyc;
        int hold [DEPTH];
        bit seen_valid, finished, closed, stalled, r;
        logic [N_IN-1:0]  p_idx;
        logic [N_OUT-1:0] p_data;
        logic             p_last;
`ifdef CCG_TT_SIGNATURE_EN
        logic [15:0]      sig_first;
        sig_first = 16'h0;
`endif
        apply_cyc = 0; beats = 0; dones = 0; stream_cyc = 0;
        seen_valid = 0; finished = 0; closed = 0; stalled = 0;
        p_idx = '0; p_data = '0; p_last = 1'b0;
        for (int i = 0; i < DEPTH; i++) hold[i] = 0;
        @(negedge clk);
        start_r[g] = 1'b1;
        ready_r[g] = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            start_r[g] = 1'b0;
            if (finished) begin
                chk({tag, " idle_after_done"}, 32'(busy_w[g]), 32'd0);
                closed = 1;
                break;
            end
            if (done_w[g]) begin
                dones++;
                chk({tag, " done_valid_low"}, 32'(valid_w[g]), 32'd0);
                chk({tag, " beat_count"}, 32'(beats), 32'(DEPTH));
                chk({tag, " x_hold_last"}, 32'(x_w[g]), 32'(DEPTH - 1));
`ifdef CCG_TT_SIGNATURE_EN
                chk({tag, " sig_ref"}, 32'(sig_w[g]), 32'(model_sig()));
                chk({tag, " sig_stable"}, 32'(sig_w[g]), 32'(sig_first));
`endif
                if (start_at_done) start_r[g] = 1'b1;
                finished = 1;
            end else if (!valid_w[g]) begin
                if (seen_valid) begin
                    chk({tag, " valid_dropped"}, 32'(valid_w[g]), 32'd1);
                end else begin
                    apply_cyc++;
                    hold[int'(x_w[g])]++;
                    if (poke_apply && apply_cyc == 5) start_r[g] = 1'b1;
                end
            end else begin
                if (!seen_valid) begin
                    seen_valid = 1;
`ifdef CCG_TT_SIGNATURE_EN
                    sig_first = sig_w[g];
`endif
                    chk({tag, " apply_cycles"}, 32'(apply_cyc), 32'(exp_apply));
                    for (int i = 0; i < DEPTH; i++)
                        if (hold[i] != exp_apply / DEPTH)
                            chk({tag, " pattern_hold"}, 32'(hold[i]), 32'(exp_apply / DEPTH));
                end
                if (stalled) begin
                    chk({tag, " stall_index"}, 32'(index_w[g]), 32'(p_idx));
                    chk({tag, " stall_data"}, 32'(data_w[g]), 32'(p_data));
                    chk({tag, " stall_last"}, 32'(last_w[g]), 32'(p_last));
                end
                case (rmode)
                    0:       r = 1'b1;
                    1:       r = ((stream_cyc % 4) == 0) || ((stream_cyc % 4) == 3);
                    default: r = 1'($urandom_range(0, 1));
                endcase
                ready_r[g] = r;
                if (r) begin
                    chk({tag, " beat_index"}, 32'(index_w[g]), 32'(beats));
                    chk({tag, " beat_data"}, 32'(data_w[g]), 32'(model_f(beats)));
                    chk({tag, " beat_last"}, 32'(last_w[g]), 32'(beats == DEPTH - 1));
                    if (beats < DEPTH) cap[g][beats] = data_w[g];
                    beats++;
                end
                stalled = !r;
                p_idx = index_w[g]; p_data = data_w[g]; p_last = last_w[g];
                if (poke_stream && stream_cyc == 3) start_r[g] = 1'b1;
                stream_cyc++;
            end
            @(negedge clk);
        end
        start_r[g] = 1'b0;
        ready_r[g] = 1'b1;
        chk({tag, " sweep_finished"}, 32'(closed), 32'd1);
        chk({tag, " done_count"}, 32'(dones), 32'd1);
    endtask

    typedef struct {
        int g;
        int rmode;
        bit use_lut;
        bit poke_apply;
        bit poke_stream;
        bit start_at_done;
        int exp_apply;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit reached;
        vecs[0] = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32};
        vecs[1] = '{0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32};
        vecs[2] = '{0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 32};
        vecs[3] = '{1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16};
        vecs[4] = '{2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64};
        vecs[5] = '{0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 32};
        vecs[6] = '{1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 16};
        vecs[7] = '{2, 1, 1'b1, 1'b0, 1'b0, 1'b1, 64};

        for (int g = 0; g < NDUT; g++) begin
            rst_r[g] = 1'b1; start_r[g] = 1'b0; ready_r[g] = 1'b1;
        end
        for (int j = 0; j < DEPTH; j++) lut[j] = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            chk("reset_busy", 32'(busy_w[g]), 32'd0);
            chk("reset_done", 32'(done_w[g]), 32'd0);
            chk("reset_valid", 32'(valid_w[g]), 32'd0);
            chk("reset_last", 32'(last_w[g]), 32'd0);
            chk("reset_x", 32'(x_w[g]), 32'd0);
            chk("reset_index", 32'(index_w[g]), 32'd0);
            chk("reset_data", 32'(data_w[g]), 32'd0);
`ifdef CCG_TT_SIGNATURE_EN
            chk("reset_sig", 32'(sig_w[g]), 32'd0);
`endif
            rst_r[g] = 1'b0;
        end

        for (int v = 0; v < 8; v++) begin
            use_lut = vecs[v].use_lut;
            if (use_lut)
                for (int j = 0; j < DEPTH; j++) lut[j] = 5'($urandom());
            run_sweep(vecs[v].g, vecs[v].rmode, vecs[v].poke_apply, vecs[v].poke_stream,
                      vecs[v].start_at_done, vecs[v].exp_apply, $sformatf("vec%0d", v));
        end

        // SETTLE=0 and SETTLE=3 must capture the same table for one CUT.
        use_lut = 1'b1;
        for (int j = 0; j < DEPTH; j++) lut[j] = 5'($urandom());
        run_sweep(1, 0, 1'b0, 1'b0, 1'b0, 16, "settle0");
        run_sweep(2, 0, 1'b0, 1'b0, 1'b0, 64, "settle3");
        for (int j = 0; j < DEPTH; j++)
            chk("settle_tables_equal", 32'(cap[1][j]), 32'(cap[2][j]));

        // Reset while beat 7 is presented, then a clean full sweep.
        use_lut = 1'b0;
        @(negedge clk);
        start_r[0] = 1'b1;
        ready_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        reached = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (valid_w[0] && index_w[0] == 4'd7) begin
                reached = 1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_reached_beat7", 32'(reached), 32'd1);
        rst_r[0] = 1'b1;
        @(negedge clk);
        rst_r[0] = 1'b0;
        chk("abort_busy", 32'(busy_w[0]), 32'd0);
        chk("abort_valid", 32'(valid_w[0]), 32'd0);
        chk("abort_x", 32'(x_w[0]), 32'd0);
        chk("abort_done", 32'(done_w[0]), 32'd0);
        chk("abort_last", 32'(last_w[0]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done_w[0]), 32'd0);
            chk("abort_stays_idle", 32'(busy_w[0]), 32'd0);
        end
        run_sweep(0, 1, 1'b0, 1'b0, 1'b0, 32, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
